// File: rtl/cnt_pkg.sv
// Shared constants and the load-clamp helper for the up/down counter.
package cnt_pkg;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // Widest supported counter; the clamp helper works at this width.
    localparam int unsigned CNT_MAX_W = 16;

    // Out-of-range load values are pulled down to the top of the count range.
    function automatic logic [CNT_MAX_W-1:0] clamp_load(input logic [CNT_MAX_W-1:0] din,
                                                        input int unsigned        modulus);
        if (32'(din) >= modulus) begin
            return CNT_MAX_W'(modulus - 32'd1);
        end
        return din;
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle between a counter user and the counter.
interface mod_updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] din_load;
    logic             enable;
    logic             up_dn;
    logic [WIDTH-1:0] dout_q;
    logic             dout_tc;
    logic             dout_wrap;

    modport master (
        output clr, load, din_load, enable, up_dn,
        input  dout_q, dout_tc, dout_wrap
    );

    modport slave (
        input  clr, load, din_load, enable, up_dn,
        output dout_q, dout_tc, dout_wrap
    );
endinterface

// File: rtl/mod_updown_counter_step.sv
// Combinational next-count and limit detection for one enabled step.
module cnt_step
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q_next,
    output logic             limit_evt
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 32'd1);
    localparam bit               SAT   = (SATURATE == MODE_SAT);

    // Up-limit uses >= so a stray out-of-range value can never step further out.
    always_comb begin
        q_next    = q;
        limit_evt = 1'b0;
        if (up_dn == CNT_UP) begin
            if (q >= Q_MAX) begin
                limit_evt = 1'b1;
                q_next    = SAT ? Q_MAX : '0;
            end else begin
                q_next = q + WIDTH'(1);
            end
        end else begin
            if (q == '0) begin
                limit_evt = 1'b1;
                q_next    = SAT ? '0 : Q_MAX;
            end else begin
                q_next = q - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised synchronous up/down counter with clear, load, wrap/saturate and flags.
module mod_updown_counter
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic                       clock,
    input  logic                       reset,
    mod_updown_counter_if.slave        bus
);

    if (WIDTH < 2 || WIDTH > CNT_MAX_W) begin : g_bad_width
        $error("mod_updown_counter: WIDTH out of range 2..16");
    end
    if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS out of range 2..2**WIDTH");
    end
    if (SATURATE > MODE_SAT) begin : g_bad_mode
        $error("mod_updown_counter: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] q_r, q_nxt, step_q, load_val;
    logic             tc_r, tc_nxt, wrap_r, wrap_nxt, step_limit;

    cnt_step #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_step (
        .q         (q_r),
        .up_dn     (bus.up_dn),
        .q_next    (step_q),
        .limit_evt (step_limit)
    );

    assign load_val = WIDTH'(clamp_load(CNT_MAX_W'(bus.din_load), MODULUS));

    // Priority: clr > load > enable > hold; tc only survives an enabled limit event.
    always_comb begin
        q_nxt    = q_r;
        tc_nxt   = 1'b0;
        wrap_nxt = wrap_r;
        if (bus.clr) begin
            q_nxt    = '0;
            wrap_nxt = 1'b0;
        end else if (bus.load) begin
            q_nxt = load_val;
        end else if (bus.enable) begin
            q_nxt    = step_q;
            tc_nxt   = step_limit;
            wrap_nxt = wrap_r | step_limit;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_r    <= '0;
            tc_r   <= 1'b0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            tc_r   <= tc_nxt;
            wrap_r <= wrap_nxt;
        end
    end

    assign bus.dout_q    = q_r;
    assign bus.dout_tc   = tc_r;
    assign bus.dout_wrap = wrap_r;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed-vector bench: wrap (M=10), saturate (M=10) and full-range (M=16) counters.
module tb_mod_updown_counter;

    localparam int unsigned W = 4;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    mod_updown_counter_if #(.WIDTH(W)) a ();
    mod_updown_counter_if #(.WIDTH(W)) b ();
    mod_updown_counter_if #(.WIDTH(W)) c ();

    mod_updown_counter #(.WIDTH(W), .MODULUS(10), .SATURATE(0)) u_wrap (
        .clock (clk), .reset (rst_n), .bus (a));
    mod_updown_counter #(.WIDTH(W), .MODULUS(10), .SATURATE(1)) u_sat (
        .clock (clk), .reset (rst_n), .bus (b));
    mod_updown_counter #(.WIDTH(W), .MODULUS(16), .SATURATE(0)) u_full (
        .clock (clk), .reset (rst_n), .bus (c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a.clr = 0; a.load = 0; a.din_load = '0; a.enable = 0; a.up_dn = 1;
        b.clr = 0; b.load = 0; b.din_load = '0; b.enable = 0; b.up_dn = 1;
        c.clr = 0; c.load = 0; c.din_load = '0; c.enable = 0; c.up_dn = 1;
        tick(); tick();
        check_eq("rst q",    32'(a.dout_q), 0);
        check_eq("rst tc",   32'(a.dout_tc), 0);
        check_eq("rst wrap", 32'(a.dout_wrap), 0);

        // Count to 7 then assert reset between edges
        rst_n = 1'b1;
        a.enable = 1; a.up_dn = 1;
        for (int i = 0; i < 7; i++) tick();
        check_eq("pre-rst q", 32'(a.dout_q), 7);
        rst_n = 1'b0;
        #1;
        check_eq("async rst q",    32'(a.dout_q), 0);
        check_eq("async rst tc",   32'(a.dout_tc), 0);
        check_eq("async rst wrap", 32'(a.dout_wrap), 0);
        tick();
        rst_n = 1'b1;
        tick(); check_eq("post-rst q1", 32'(a.dout_q), 1);
        tick(); check_eq("post-rst q2", 32'(a.dout_q), 2);
        tick(); check_eq("post-rst q3", 32'(a.dout_q), 3);

        // Wrap up from 8
        a.enable = 0; a.load = 1; a.din_load = 4'd8;
        tick(); check_eq("ld8 q", 32'(a.dout_q), 8);
        a.load = 0; a.enable = 1; a.up_dn = 1;
        tick(); check_eq("wu9 q", 32'(a.dout_q), 9);
        check_eq("wu9 tc", 32'(a.dout_tc), 0);
        check_eq("wu9 wrap", 32'(a.dout_wrap), 0);
        tick(); check_eq("wu0 q", 32'(a.dout_q), 0);
        check_eq("wu0 tc", 32'(a.dout_tc), 1);
        check_eq("wu0 wrap", 32'(a.dout_wrap), 1);
        tick(); check_eq("wu1 q", 32'(a.dout_q), 1);
        check_eq("wu1 tc", 32'(a.dout_tc), 0);
        check_eq("wu1 wrap", 32'(a.dout_wrap), 1);

        // Wrap down from 1
        a.enable = 0; a.load = 1; a.din_load = 4'd1;
        tick(); check_eq("ld1 q", 32'(a.dout_q), 1);
        check_eq("ld1 wrap kept", 32'(a.dout_wrap), 1);
        a.load = 0; a.enable = 1; a.up_dn = 0;
        tick(); check_eq("wd0 q", 32'(a.dout_q), 0);
        check_eq("wd0 tc", 32'(a.dout_tc), 0);
        tick(); check_eq("wd9 q", 32'(a.dout_q), 9);
        check_eq("wd9 tc", 32'(a.dout_tc), 1);
        tick(); check_eq("wd8 q", 32'(a.dout_q), 8);
        check_eq("wd8 tc", 32'(a.dout_tc), 0);

        // Hold with enable low
        a.enable = 0;
        tick(); check_eq("hold q", 32'(a.dout_q), 8);
        check_eq("hold tc", 32'(a.dout_tc), 0);

        // Saturating counter from 8
        b.load = 1; b.din_load = 4'd8;
        tick(); check_eq("sat ld8 q", 32'(b.dout_q), 8);
        b.load = 0; b.enable = 1; b.up_dn = 1;
        tick(); check_eq("sat e1 q", 32'(b.dout_q), 9);
        check_eq("sat e1 tc", 32'(b.dout_tc), 0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_eq($sformatf("sat e%0d q", i), 32'(b.dout_q), 9);
            check_eq($sformatf("sat e%0d tc", i), 32'(b.dout_tc), 1);
        end
        check_eq("sat wrap", 32'(b.dout_wrap), 1);
        b.up_dn = 0;
        tick(); check_eq("sat dn q", 32'(b.dout_q), 8);
        check_eq("sat dn tc", 32'(b.dout_tc), 0);
        b.enable = 0;

        // Load and clamp
        a.load = 1; a.din_load = 4'd5;
        tick(); check_eq("ld5 q", 32'(a.dout_q), 5);
        a.din_load = 4'd13;
        tick(); check_eq("ld13 clamp q", 32'(a.dout_q), 9);
        a.din_load = 4'd3; a.enable = 1; a.up_dn = 1;
        tick(); check_eq("ld+en q", 32'(a.dout_q), 3);
        check_eq("ld+en tc", 32'(a.dout_tc), 0);

        // Priority: clr beats load and a same-edge limit event
        a.enable = 0; a.din_load = 4'd9;
        tick(); check_eq("pri ld9 q", 32'(a.dout_q), 9);
        check_eq("pri pre wrap", 32'(a.dout_wrap), 1);
        a.clr = 1; a.load = 1; a.din_load = 4'd4; a.enable = 1; a.up_dn = 1;
        tick(); check_eq("pri q", 32'(a.dout_q), 0);
        check_eq("pri tc", 32'(a.dout_tc), 0);
        check_eq("pri wrap", 32'(a.dout_wrap), 0);
        a.clr = 0; a.load = 0; a.enable = 0;

        // Full-range modulus: 15 -> 0
        c.load = 1; c.din_load = 4'd15;
        tick(); check_eq("m16 ld q", 32'(c.dout_q), 15);
        c.load = 0; c.enable = 1; c.up_dn = 1;
        tick(); check_eq("m16 wrap q", 32'(c.dout_q), 0);
        check_eq("m16 wrap tc", 32'(c.dout_tc), 1);
        check_eq("m16 wrap flag", 32'(c.dout_wrap), 1);
        c.up_dn = 0;
        tick(); check_eq("m16 dn q", 32'(c.dout_q), 15);
        check_eq("m16 dn tc", 32'(c.dout_tc), 1);
        c.enable = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
